// File: rtl/star_hub.sv
// Star hub: one FIFO per endpoint, per-output round-robin arbitration into a one-entry output register.
// Optional per-output delivered-flit counters are built only when STAR_HUB_STATS_EN is defined.
module star_hub #(
    parameter int N_PORTS    = 4,
    parameter int FLIT_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          in_valid,
    input  logic [N_PORTS*FLIT_W-1:0]   in_flit,
    output logic [N_PORTS-1:0]          in_ready,
    output logic [N_PORTS-1:0]          out_valid,
    output logic [N_PORTS*FLIT_W-1:0]   out_flit,
    input  logic [N_PORTS-1:0]          out_ready,
    output logic [N_PORTS-1:0]          drop_err,
    output logic [N_PORTS*16-1:0]       stat_cnt
);
    localparam int DEST_W = $clog2(N_PORTS);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    logic [FLIT_W-1:0] mem [N_PORTS][FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr [N_PORTS];
    logic [AW-1:0]     wr_ptr [N_PORTS];
    logic [CW-1:0]     count  [N_PORTS];
    logic              alive;

    logic [N_PORTS-1:0] head_valid, head_bad, pop, push;
    logic [FLIT_W-1:0]  head_flit [N_PORTS];
    logic [DEST_W-1:0]  head_dest [N_PORTS];

    logic [DEST_W-1:0]  rr_ptr    [N_PORTS];
    logic [N_PORTS-1:0] grant     [N_PORTS];
    logic [N_PORTS-1:0] grant_any;
    logic [DEST_W-1:0]  grant_idx [N_PORTS];

    // in_ready stays low through reset and rises on the first edge after it
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            in_ready[i]   = alive && (count[i] != CW'(FIFO_DEPTH));
            push[i]       = in_valid[i] && in_ready[i];
            head_flit[i]  = mem[i][rd_ptr[i]];
            head_dest[i]  = head_flit[i][DEST_W-1:0];
            head_valid[i] = (count[i] != '0);
            head_bad[i]   = head_valid[i] && (int'(head_dest[i]) >= N_PORTS);
        end
    end

    assign drop_err = head_bad;

    always_comb begin : arb
        int idx;
        idx = 0;
        for (int j = 0; j < N_PORTS; j++) begin
            grant[j]     = '0;
            grant_any[j] = 1'b0;
            grant_idx[j] = '0;
            if (!out_valid[j] || out_ready[j]) begin
                for (int k = 0; k < N_PORTS; k++) begin
                    idx = int'(rr_ptr[j]) + k;
                    if (idx >= N_PORTS) idx = idx - N_PORTS;
                    if (!grant_any[j] && head_valid[idx] && !head_bad[idx] &&
                        int'(head_dest[idx]) == j) begin
                        grant_any[j]   = 1'b1;
                        grant[j][idx]  = 1'b1;
                        grant_idx[j]   = DEST_W'(idx);
                    end
                end
            end
        end
    end

    // bad-destination heads are popped without delivery
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            pop[i] = head_bad[i];
            for (int j = 0; j < N_PORTS; j++) pop[i] = pop[i] | grant[j][i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= in_flit[i*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alive     <= 1'b0;
            out_valid <= '0;
            out_flit  <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                rr_ptr[i] <= '0;
            end
        end else begin
            alive <= 1'b1;
            for (int i = 0; i < N_PORTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            for (int j = 0; j < N_PORTS; j++) begin
                if (grant_any[j]) begin
                    out_valid[j]                  <= 1'b1;
                    out_flit[j*FLIT_W +: FLIT_W]  <= head_flit[grant_idx[j]];
                    if (int'(grant_idx[j]) == N_PORTS - 1) rr_ptr[j] <= '0;
                    else                                   rr_ptr[j] <= grant_idx[j] + 1'b1;
                end else if (out_ready[j]) begin
                    out_valid[j] <= 1'b0;
                end
            end
        end
    end

`ifdef STAR_HUB_STATS_EN
    logic [15:0] cnt [N_PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_PORTS; j++) cnt[j] <= '0;
        end else begin
            for (int j = 0; j < N_PORTS; j++)
                if (out_valid[j] && out_ready[j] && cnt[j] != 16'hFFFF) cnt[j] <= cnt[j] + 16'd1;
        end
    end

    always_comb begin
        for (int j = 0; j < N_PORTS; j++) stat_cnt[j*16 +: 16] = cnt[j];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
